input_accumulator: RTL and testbench



---
 rtl/input_accumulator.sv | 126 ++++++++++++
 tb/tb_input_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/input_accumulator.sv
// Frame accumulator: sums PIX_W-bit samples and counts them between
// FrameStart and FrameEnd. On frame close it presents the sum and count, with a
// one-cycle StartOut strobe, to the divider-based averaging stage.
module input_accumulator #(
   parameter int PIX_W = 8,
   parameter int CNT_W = 20,
   parameter int SUM_W = 28
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [PIX_W-1:0] PixelIn,
   input  logic             ValidIn,
   input  logic             FrameStart,
   input  logic             FrameEnd,
   output logic [SUM_W-1:0] DataOut,
   output logic [CNT_W-1:0] Divisor,
   output logic             StartOut,
   output logic             Overflow,
   output logic             FrameError
);

   localparam logic IDLE  = 1'b0;
   localparam logic ACCUM = 1'b1;

   localparam int              ACC_W   = 1 + SUM_W + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             state;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic             acc_drop;
   logic [SUM_W-1:0] acc_sum;
   logic [CNT_W-1:0] acc_cnt;
   logic [SUM_W-1:0] ld_sum;
   logic [CNT_W-1:0] ld_cnt;

   // Adds one sample to the running sum/count. When the count is already at
   // its maximum the sample is dropped and the drop bit (MSB) is raised; the
   // sum cannot wrap because SUM_W >= PIX_W + CNT_W.
   function automatic logic [ACC_W-1:0] sat_accum(
      input logic [SUM_W-1:0] s,
      input logic [CNT_W-1:0] c,
      input logic             v,
      input logic [PIX_W-1:0] p
   );
      if (!v) begin
         return {1'b0, s, c};
      end
      if (c == CNT_MAX) begin
         return {1'b1, s, c};
      end
      return {1'b0, s + SUM_W'(p), c + CNT_W'(1)};
   endfunction

   // Next-sample sum/count, and the load values used when a frame opens.
   always_comb begin
      {acc_drop, acc_sum, acc_cnt} = sat_accum(sum, cnt, ValidIn, PixelIn);
      ld_sum = ValidIn ? SUM_W'(PixelIn) : '0;
      ld_cnt = ValidIn ? CNT_W'(1) : '0;
   end

   // Frame FSM, accumulator, and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         sum        <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         DataOut    <= '0;
         Divisor    <= '0;
         StartOut   <= 1'b0;
         Overflow   <= 1'b0;
         FrameError <= 1'b0;
      end else begin
         StartOut   <= 1'b0;
         FrameError <= 1'b0;
         case (state)
            IDLE: begin
               // A close with no open frame is a protocol error.
               FrameError <= FrameEnd;
               if (FrameStart) begin
                  state <= ACCUM;
                  sum   <= ld_sum;
                  cnt   <= ld_cnt;
                  ovf   <= 1'b0;
               end
            end
            default: begin
               if (FrameEnd) begin
                  // The same-cycle sample belongs to the closing frame. An
                  // empty frame is never passed on, so the divider never sees
                  // a zero divisor.
                  if (acc_cnt == '0) begin
                     FrameError <= 1'b1;
                  end else begin
                     DataOut  <= acc_sum;
                     Divisor  <= acc_cnt;
                     Overflow <= ovf | acc_drop;
                     StartOut <= 1'b1;
                  end
                  if (FrameStart) begin
                     sum <= '0;
                     cnt <= '0;
                     ovf <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (FrameStart) begin
                  // Restart without a close: drop the open frame.
                  FrameError <= 1'b1;
                  sum        <= ld_sum;
                  cnt        <= ld_cnt;
                  ovf        <= 1'b0;
               end else begin
                  sum <= acc_sum;
                  cnt <= acc_cnt;
                  ovf <= ovf | acc_drop;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_accumulator.sv
// Bench for input_accumulator: a cycle-by-cycle vector table on the default
// build, plus a saturation sequence on a narrow-counter build.
module tb_input_accumulator;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // Default build (PIX_W=8, CNT_W=20, SUM_W=28)
   logic        reset_n = 1'b0;
   logic [7:0]  pix = '0;
   logic        vld = 1'b0, fs = 1'b0, fe = 1'b0;
   logic [27:0] dout;
   logic [19:0] div;
   logic        so, ovf, ferr;

   input_accumulator dut (
      .clock(clock), .reset_n(reset_n), .PixelIn(pix), .ValidIn(vld),
      .FrameStart(fs), .FrameEnd(fe), .DataOut(dout), .Divisor(div),
      .StartOut(so), .Overflow(ovf), .FrameError(ferr)
   );

   // Narrow build (CNT_W=4, SUM_W=12)
   logic        s_reset_n = 1'b0;
   logic [7:0]  s_pix = '0;
   logic        s_vld = 1'b0, s_fs = 1'b0, s_fe = 1'b0;
   logic [11:0] s_dout;
   logic [3:0]  s_div;
   logic        s_so, s_ovf, s_ferr;

   input_accumulator #(.PIX_W(8), .CNT_W(4), .SUM_W(12)) dut_s (
      .clock(clock), .reset_n(s_reset_n), .PixelIn(s_pix), .ValidIn(s_vld),
      .FrameStart(s_fs), .FrameEnd(s_fe), .DataOut(s_dout), .Divisor(s_div),
      .StartOut(s_so), .Overflow(s_ovf), .FrameError(s_ferr)
   );

   typedef struct {
      logic        rn, fs, fe, v;
      logic [7:0]  pix;
      logic        so;
      logic [27:0] dout;
      logic [19:0] div;
      logic        ovf, ferr;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic add(input logic rn_i, fs_i, fe_i, v_i, input logic [7:0] pix_i,
                      input logic so_i, input logic [27:0] d_i, input logic [19:0] dv_i,
                      input logic ovf_i, ferr_i);
      vec_t r;
      r.rn = rn_i; r.fs = fs_i; r.fe = fe_i; r.v = v_i; r.pix = pix_i;
      r.so = so_i; r.dout = d_i; r.div = dv_i; r.ovf = ovf_i; r.ferr = ferr_i;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0d want %0d", name, idx, act, exp);
      end
   endtask

   task automatic s_cycle(input logic rn_i, fs_i, fe_i, v_i, input logic [7:0] p_i);
      @(negedge clock);
      s_reset_n = rn_i; s_fs = fs_i; s_fe = fe_i; s_vld = v_i; s_pix = p_i;
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Each row: inputs for one edge, then outputs expected just after it.
      //   rn fs fe v  pix   so dout div ovf ferr
      add(0, 0, 0, 0, 0,    0, 0,   0,  0, 0);   // reset
      add(0, 0, 0, 0, 0,    0, 0,   0,  0, 0);
      // plain frame 10,20,30,40
      add(1, 1, 0, 0, 0,    0, 0,   0,  0, 0);
      add(1, 0, 0, 1, 10,   0, 0,   0,  0, 0);
      add(1, 0, 0, 1, 20,   0, 0,   0,  0, 0);
      add(1, 0, 0, 1, 30,   0, 0,   0,  0, 0);
      add(1, 0, 0, 1, 40,   0, 0,   0,  0, 0);
      add(1, 0, 1, 0, 0,    1, 100, 4,  0, 0);
      add(1, 0, 0, 0, 0,    0, 100, 4,  0, 0);
      // edge samples on FrameStart and FrameEnd cycles
      add(1, 1, 0, 1, 255,  0, 100, 4,  0, 0);
      add(1, 0, 0, 1, 255,  0, 100, 4,  0, 0);
      add(1, 0, 1, 1, 255,  1, 765, 3,  0, 0);
      add(1, 0, 0, 0, 0,    0, 765, 3,  0, 0);
      // empty frame
      add(1, 1, 0, 0, 0,    0, 765, 3,  0, 0);
      add(1, 0, 1, 0, 0,    0, 765, 3,  0, 1);
      add(1, 0, 0, 0, 0,    0, 765, 3,  0, 0);
      // close and reopen in one cycle
      add(1, 1, 0, 0, 0,    0, 765, 3,  0, 0);
      add(1, 0, 0, 1, 1,    0, 765, 3,  0, 0);
      add(1, 0, 0, 1, 2,    0, 765, 3,  0, 0);
      add(1, 1, 1, 0, 0,    1, 3,   2,  0, 0);
      add(1, 0, 0, 1, 7,    0, 3,   2,  0, 0);
      add(1, 0, 1, 0, 0,    1, 7,   1,  0, 0);
      add(1, 0, 0, 0, 0,    0, 7,   1,  0, 0);
      // FrameEnd while idle
      add(1, 0, 1, 0, 0,    0, 7,   1,  0, 1);
      add(1, 0, 0, 0, 0,    0, 7,   1,  0, 0);
      // restart mid-frame discards 5,6 and keeps 3
      add(1, 1, 0, 1, 5,    0, 7,   1,  0, 0);
      add(1, 0, 0, 1, 6,    0, 7,   1,  0, 0);
      add(1, 1, 0, 1, 3,    0, 7,   1,  0, 1);
      add(1, 0, 1, 1, 4,    1, 7,   2,  0, 0);
      add(1, 0, 0, 0, 0,    0, 7,   2,  0, 0);
      // reset mid-frame
      add(1, 1, 0, 0, 0,    0, 7,   2,  0, 0);
      add(1, 0, 0, 1, 1,    0, 7,   2,  0, 0);
      add(1, 0, 0, 1, 2,    0, 7,   2,  0, 0);
      add(1, 0, 0, 1, 3,    0, 7,   2,  0, 0);
      add(1, 0, 0, 1, 4,    0, 7,   2,  0, 0);
      add(1, 0, 0, 1, 5,    0, 7,   2,  0, 0);
      add(0, 0, 1, 1, 6,    0, 0,   0,  0, 0);
      add(1, 0, 0, 0, 0,    0, 0,   0,  0, 0);
      add(1, 1, 0, 1, 9,    0, 0,   0,  0, 0);
      add(1, 0, 1, 0, 0,    1, 9,   1,  0, 0);
      add(1, 0, 0, 0, 0,    0, 9,   1,  0, 0);

      foreach (tbl[i]) begin
         @(negedge clock);
         reset_n = tbl[i].rn; fs = tbl[i].fs; fe = tbl[i].fe;
         vld = tbl[i].v; pix = tbl[i].pix;
         @(posedge clock);
         #1;
         chk("StartOut",   i, 32'(so),   32'(tbl[i].so));
         chk("DataOut",    i, 32'(dout), 32'(tbl[i].dout));
         chk("Divisor",    i, 32'(div),  32'(tbl[i].div));
         chk("Overflow",   i, 32'(ovf),  32'(tbl[i].ovf));
         chk("FrameError", i, 32'(ferr), 32'(tbl[i].ferr));
      end

      // Narrow counter: 17 samples of 1 saturate at 15.
      s_cycle(0, 0, 0, 0, 0);
      chk("sat_reset_div", 0, 32'(s_div), 32'd0);
      s_cycle(1, 1, 0, 0, 0);
      for (int k = 0; k < 17; k++) s_cycle(1, 0, 0, 1, 1);
      chk("sat_no_strobe", 1, 32'(s_so), 32'd0);
      s_cycle(1, 0, 1, 0, 0);
      chk("sat_strobe",   2, 32'(s_so),   32'd1);
      chk("sat_dataout",  2, 32'(s_dout), 32'd15);
      chk("sat_divisor",  2, 32'(s_div),  32'd15);
      chk("sat_overflow", 2, 32'(s_ovf),  32'd1);
      chk("sat_ferr",     2, 32'(s_ferr), 32'd0);
      s_cycle(1, 0, 0, 0, 0);
      chk("sat_strobe_off", 3, 32'(s_so),  32'd0);
      chk("sat_ovf_hold",   3, 32'(s_ovf), 32'd1);
      // Next normal frame clears the overflow report.
      s_cycle(1, 1, 0, 1, 2);
      s_cycle(1, 0, 1, 0, 0);
      chk("next_strobe",   4, 32'(s_so),   32'd1);
      chk("next_dataout",  4, 32'(s_dout), 32'd2);
      chk("next_divisor",  4, 32'(s_div),  32'd1);
      chk("next_overflow", 4, 32'(s_ovf),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
